// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I constants and fetch state encoding
package rv32_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int          PC_STEP  = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_inst_buf.sv
// rtl/fetch_inst_buf.sv - one-entry instruction/PC holding register for decode
module fetch_inst_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [31:0]     load_inst,
  input  logic [XLEN-1:0] load_pc,
  input  logic            consume,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc
);
  import rv32_pkg::*;

  // clear beats load so a redirect squashes a response landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= INST_NOP;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32_fetch_pc_unit.sv
// rtl/rv32_fetch_pc_unit.sv - RV32I program counter and single-outstanding instruction fetch
module rv32_fetch_pc_unit #(
  parameter int              XLEN     = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            ip_clk,
  input  logic            ip_rst,
  input  logic            ip_Redirect,
  input  logic [XLEN-1:0] ip_Target,
  output logic            op_Imem_Req,
  output logic [XLEN-1:0] op_Imem_Addr,
  input  logic            ip_Imem_Ready,
  input  logic            ip_Imem_Valid,
  input  logic [31:0]     ip_Imem_Data,
  output logic            op_Inst_Valid,
  output logic [31:0]     op_Inst,
  output logic [XLEN-1:0] op_Inst_PC,
  input  logic            ip_Dec_Ready,
  output logic            op_Fault
);
  import rv32_pkg::*;

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            kill, kill_n;
  logic            fault, fault_n;
  logic            buf_valid, buf_load, buf_clear;
  logic            accept, consume, resp_pending, misaligned;

  assign misaligned   = ip_Target[1:0] != 2'b00;
  // a response is still owed after this edge; outside WAIT only a killed one can be
  assign resp_pending = ((state == WAIT) | kill) & !ip_Imem_Valid;

  // kill in REQ means a pre-reset response is still due; hold off so only one is ever in flight
  assign op_Imem_Req   = (state == REQ) & (!buf_valid | ip_Dec_Ready) & !ip_Redirect
                         & !kill & !ip_rst;
  assign op_Imem_Addr  = pc;
  assign accept        = op_Imem_Req & ip_Imem_Ready;
  assign op_Inst_Valid = buf_valid & !ip_Redirect;
  assign consume       = op_Inst_Valid & ip_Dec_Ready;
  assign op_Fault      = fault;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    kill_n    = kill;
    fault_n   = fault;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      REQ: begin
        if (ip_Imem_Valid) kill_n = 1'b0;
        if (accept) state_n = WAIT;
      end
      WAIT: begin
        if (ip_Imem_Valid) begin
          state_n = REQ;
          kill_n  = 1'b0;
          if (!kill) begin
            buf_load = 1'b1;
            pc_n     = pc + XLEN'(PC_STEP);
          end
        end
      end
      HALT: begin
        if (ip_Imem_Valid) kill_n = 1'b0;
      end
      default: state_n = REQ;
    endcase
    if (ip_Redirect && state != HALT) begin
      buf_load  = 1'b0;
      buf_clear = 1'b1;
      pc_n      = ip_Target;
      kill_n    = resp_pending;
      if (misaligned) begin
        state_n = HALT;
        fault_n = 1'b1;
      end else begin
        state_n = (state == WAIT && resp_pending) ? WAIT : REQ;
      end
    end
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state <= REQ;
      pc    <= RESET_PC;
      kill  <= resp_pending;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
      fault <= fault_n;
    end
  end

  fetch_inst_buf #(.XLEN(XLEN)) u_inst_buf (
    .clk       (ip_clk),
    .rst       (ip_rst),
    .clear     (buf_clear),
    .load      (buf_load),
    .load_inst (ip_Imem_Data),
    .load_pc   (pc),
    .consume   (consume),
    .valid     (buf_valid),
    .inst      (op_Inst),
    .pc        (op_Inst_PC)
  );

endmodule

// File: tb/tb_rv32_fetch_pc_unit.sv
// tb/tb_rv32_fetch_pc_unit.sv - directed self-checking bench for rv32_fetch_pc_unit
module tb_rv32_fetch_pc_unit;

  logic        ip_clk = 1'b0;
  logic        ip_rst;
  logic        ip_Redirect;
  logic [31:0] ip_Target;
  logic        op_Imem_Req;
  logic [31:0] op_Imem_Addr;
  logic        ip_Imem_Ready;
  logic        ip_Imem_Valid = 1'b0;
  logic [31:0] ip_Imem_Data = 32'h0;
  logic        op_Inst_Valid;
  logic [31:0] op_Inst;
  logic [31:0] op_Inst_PC;
  logic        ip_Dec_Ready;
  logic        op_Fault;

  int n_checks = 0;
  int n_pass   = 0;

  int          mem_lat  = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;

  rv32_fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .ip_clk        (ip_clk),
    .ip_rst        (ip_rst),
    .ip_Redirect   (ip_Redirect),
    .ip_Target     (ip_Target),
    .op_Imem_Req   (op_Imem_Req),
    .op_Imem_Addr  (op_Imem_Addr),
    .ip_Imem_Ready (ip_Imem_Ready),
    .ip_Imem_Valid (ip_Imem_Valid),
    .ip_Imem_Data  (ip_Imem_Data),
    .op_Inst_Valid (op_Inst_Valid),
    .op_Inst       (op_Inst),
    .op_Inst_PC    (op_Inst_PC),
    .ip_Dec_Ready  (ip_Dec_Ready),
    .op_Fault      (op_Fault)
  );

  always #5 ip_clk = ~ip_clk;

  // memory returns word = address after mem_lat cycles; ignores core reset
  always @(posedge ip_clk) begin
    ip_Imem_Valid <= 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        ip_Imem_Valid <= 1'b1;
        ip_Imem_Data  <= mem_addr;
        mem_busy      <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
    if (op_Imem_Req && ip_Imem_Ready) begin
      if (mem_lat <= 1) begin
        ip_Imem_Valid <= 1'b1;
        ip_Imem_Data  <= op_Imem_Addr;
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat - 1;
        mem_addr <= op_Imem_Addr;
      end
    end
  end

  task automatic do_reset();
    @(negedge ip_clk);
    ip_rst = 1'b1; ip_Redirect = 1'b0; ip_Dec_Ready = 1'b1; ip_Imem_Ready = 1'b1;
    for (int k = 0; k < 20 && (mem_busy || ip_Imem_Valid); k++) @(negedge ip_clk);
    @(negedge ip_clk);
    @(negedge ip_clk);
    ip_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ip_rst = 1'b1; ip_Redirect = 1'b0; ip_Target = 32'h0;
    ip_Imem_Ready = 1'b1; ip_Dec_Ready = 1'b1;
    repeat (3) @(negedge ip_clk);
    #1;
    n_checks++; if (op_Imem_Req !== 1'b0) $display("FAIL rst_req: got %b want 0", op_Imem_Req); else n_pass++;
    n_checks++; if (op_Inst_Valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", op_Inst_Valid); else n_pass++;
    n_checks++; if (op_Inst !== 32'h0000_0013) $display("FAIL rst_inst: got %h want 00000013", op_Inst); else n_pass++;
    n_checks++; if (op_Inst_PC !== 32'h0) $display("FAIL rst_inst_pc: got %h want 0", op_Inst_PC); else n_pass++;
    n_checks++; if (op_Fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", op_Fault); else n_pass++;
    n_checks++; if (op_Imem_Addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", op_Imem_Addr); else n_pass++;
    ip_rst = 1'b0;
    #1;
    n_checks++; if (op_Imem_Req !== 1'b1) $display("FAIL rel_req: got %b want 1", op_Imem_Req); else n_pass++;
  endtask

  task automatic test_fetch_seq();
    n_checks++; if (op_Imem_Addr !== 32'h0) $display("FAIL seq_addr0: got %h want 0", op_Imem_Addr); else n_pass++;
    @(negedge ip_clk); #1;
    n_checks++; if ({op_Imem_Req, op_Inst_Valid} !== 2'b00) $display("FAIL seq_wait: got %b want 00", {op_Imem_Req, op_Inst_Valid}); else n_pass++;
    @(negedge ip_clk); #1;
    n_checks++; if (op_Inst_Valid !== 1'b1) $display("FAIL seq_valid_lat: got %b want 1", op_Inst_Valid); else n_pass++;
    n_checks++; if ({op_Inst, op_Inst_PC} !== {32'h0, 32'h0}) $display("FAIL seq_inst0: got %h/%h want 0/0", op_Inst, op_Inst_PC); else n_pass++;
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'h4}) $display("FAIL seq_addr4: got %b/%h want 1/4", op_Imem_Req, op_Imem_Addr); else n_pass++;
    @(negedge ip_clk); #1;
    n_checks++; if (op_Inst_Valid !== 1'b0) $display("FAIL seq_consumed: got %b want 0", op_Inst_Valid); else n_pass++;
    @(negedge ip_clk); #1;
    n_checks++; if ({op_Inst_Valid, op_Inst, op_Inst_PC} !== {1'b1, 32'h4, 32'h4}) $display("FAIL seq_inst4: got %b/%h/%h want 1/4/4", op_Inst_Valid, op_Inst, op_Inst_PC); else n_pass++;
    n_checks++; if (op_Imem_Addr !== 32'h8) $display("FAIL seq_addr8: got %h want 8", op_Imem_Addr); else n_pass++;
  endtask

  task automatic test_dec_stall();
    ip_Dec_Ready = 1'b0;
    #1;
    n_checks++; if (op_Imem_Req !== 1'b0) $display("FAIL stall_req: got %b want 0", op_Imem_Req); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge ip_clk); #1;
      n_checks++;
      if ({op_Imem_Req, op_Inst_Valid, op_Inst, op_Inst_PC} !== {1'b0, 1'b1, 32'h4, 32'h4})
        $display("FAIL stall_hold[%0d]: got %b/%b/%h/%h want 0/1/4/4", i, op_Imem_Req, op_Inst_Valid, op_Inst, op_Inst_PC);
      else n_pass++;
    end
    ip_Dec_Ready = 1'b1;
    #1;
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'h8}) $display("FAIL stall_resume: got %b/%h want 1/8", op_Imem_Req, op_Imem_Addr); else n_pass++;
    @(negedge ip_clk);
    @(negedge ip_clk); #1;
    n_checks++; if ({op_Inst_Valid, op_Inst, op_Inst_PC} !== {1'b1, 32'h8, 32'h8}) $display("FAIL stall_next: got %b/%h/%h want 1/8/8", op_Inst_Valid, op_Inst, op_Inst_PC); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int k;
    logic stale;
    mem_lat = 3;
    do_reset();
    @(negedge ip_clk);
    ip_Redirect = 1'b1; ip_Target = 32'h100;
    #1;
    n_checks++; if (op_Imem_Req !== 1'b0) $display("FAIL rdw_req: got %b want 0", op_Imem_Req); else n_pass++;
    @(negedge ip_clk);
    ip_Redirect = 1'b0;
    #1;
    stale = 1'b0; k = 0;
    while (!op_Imem_Req && k < 20) begin
      if (op_Inst_Valid) stale = 1'b1;
      @(negedge ip_clk); #1; k++;
    end
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'h100}) $display("FAIL rdw_next_req: got %b/%h want 1/100", op_Imem_Req, op_Imem_Addr); else n_pass++;
    n_checks++; if (stale !== 1'b0) $display("FAIL rdw_stale: got %b want 0", stale); else n_pass++;
    mem_lat = 1;
    k = 0;
    while (!op_Inst_Valid && k < 20) begin @(negedge ip_clk); #1; k++; end
    n_checks++; if ({op_Inst_Valid, op_Inst_PC, op_Inst} !== {1'b1, 32'h100, 32'h100}) $display("FAIL rdw_inst: got %b/%h/%h want 1/100/100", op_Inst_Valid, op_Inst_PC, op_Inst); else n_pass++;
  endtask

  task automatic test_redirect_buf();
    int k;
    mem_lat = 1;
    do_reset();
    ip_Dec_Ready = 1'b0;
    k = 0;
    while (!op_Inst_Valid && k < 20) begin @(negedge ip_clk); #1; k++; end
    n_checks++; if ({op_Inst_Valid, op_Inst_PC, op_Imem_Req} !== {1'b1, 32'h0, 1'b0}) $display("FAIL rdb_full: got %b/%h/%b want 1/0/0", op_Inst_Valid, op_Inst_PC, op_Imem_Req); else n_pass++;
    ip_Dec_Ready = 1'b1; ip_Redirect = 1'b1; ip_Target = 32'h200;
    #1;
    n_checks++; if ({op_Inst_Valid, op_Imem_Req} !== 2'b00) $display("FAIL rdb_mask: got %b want 00", {op_Inst_Valid, op_Imem_Req}); else n_pass++;
    @(negedge ip_clk);
    ip_Redirect = 1'b0;
    #1;
    n_checks++; if (op_Inst_Valid !== 1'b0) $display("FAIL rdb_cleared: got %b want 0", op_Inst_Valid); else n_pass++;
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'h200}) $display("FAIL rdb_req: got %b/%h want 1/200", op_Imem_Req, op_Imem_Addr); else n_pass++;
    k = 0;
    while (!op_Inst_Valid && k < 20) begin @(negedge ip_clk); #1; k++; end
    n_checks++; if ({op_Inst_Valid, op_Inst_PC, op_Inst} !== {1'b1, 32'h200, 32'h200}) $display("FAIL rdb_inst: got %b/%h/%h want 1/200/200", op_Inst_Valid, op_Inst_PC, op_Inst); else n_pass++;
  endtask

  task automatic test_misaligned();
    int k;
    logic bad;
    mem_lat = 3;
    do_reset();
    @(negedge ip_clk);
    ip_Redirect = 1'b1; ip_Target = 32'h102;
    #1;
    n_checks++; if (op_Imem_Req !== 1'b0) $display("FAIL mis_req: got %b want 0", op_Imem_Req); else n_pass++;
    @(negedge ip_clk);
    ip_Redirect = 1'b0;
    #1;
    n_checks++; if (op_Fault !== 1'b1) $display("FAIL mis_fault: got %b want 1", op_Fault); else n_pass++;
    bad = 1'b0;
    repeat (8) begin
      if (op_Imem_Req || op_Inst_Valid) bad = 1'b1;
      @(negedge ip_clk); #1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL mis_halt_quiet: got %b want 0", bad); else n_pass++;
    n_checks++; if (op_Fault !== 1'b1) $display("FAIL mis_sticky: got %b want 1", op_Fault); else n_pass++;
    mem_lat = 1;
    do_reset();
    n_checks++; if ({op_Fault, op_Imem_Req, op_Imem_Addr} !== {1'b0, 1'b1, 32'h0}) $display("FAIL mis_restart: got %b/%b/%h want 0/1/0", op_Fault, op_Imem_Req, op_Imem_Addr); else n_pass++;
    k = 0;
    while (!op_Inst_Valid && k < 20) begin @(negedge ip_clk); #1; k++; end
    n_checks++; if ({op_Inst_Valid, op_Inst_PC} !== {1'b1, 32'h0}) $display("FAIL mis_first_pc: got %b/%h want 1/0", op_Inst_Valid, op_Inst_PC); else n_pass++;
  endtask

  task automatic test_wrap();
    int k;
    mem_lat = 1;
    do_reset();
    ip_Redirect = 1'b1; ip_Target = 32'hFFFF_FFFC;
    #1;
    n_checks++; if (op_Imem_Req !== 1'b0) $display("FAIL wrap_gate: got %b want 0", op_Imem_Req); else n_pass++;
    @(negedge ip_clk);
    ip_Redirect = 1'b0;
    #1;
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_req: got %b/%h want 1/fffffffc", op_Imem_Req, op_Imem_Addr); else n_pass++;
    k = 0;
    while (!op_Inst_Valid && k < 20) begin @(negedge ip_clk); #1; k++; end
    n_checks++; if ({op_Inst_Valid, op_Inst_PC} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_inst_pc: got %b/%h want 1/fffffffc", op_Inst_Valid, op_Inst_PC); else n_pass++;
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'h0}) $display("FAIL wrap_next: got %b/%h want 1/0", op_Imem_Req, op_Imem_Addr); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int k;
    mem_lat = 3;
    do_reset();
    ip_Redirect = 1'b1; ip_Target = 32'h40;
    @(negedge ip_clk);
    ip_Redirect = 1'b0;
    #1;
    n_checks++; if ({op_Imem_Req, op_Imem_Addr} !== {1'b1, 32'h40}) $display("FAIL riw_req: got %b/%h want 1/40", op_Imem_Req, op_Imem_Addr); else n_pass++;
    @(negedge ip_clk); #1;
    n_checks++; if (op_Imem_Req !== 1'b0) $display("FAIL riw_wait: got %b want 0", op_Imem_Req); else n_pass++;
    ip_rst = 1'b1;
    @(negedge ip_clk);
    ip_rst = 1'b0;
    #1;
    k = 0;
    while (!op_Inst_Valid && k < 40) begin @(negedge ip_clk); #1; k++; end
    n_checks++; if ({op_Inst_Valid, op_Inst_PC, op_Inst} !== {1'b1, 32'h0, 32'h0}) $display("FAIL riw_first: got %b/%h/%h want 1/0/0", op_Inst_Valid, op_Inst_PC, op_Inst); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_dec_stall();
    test_redirect_wait();
    test_redirect_buf();
    test_misaligned();
    test_wrap();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
